// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C transaction arbiter slice.
//   arb_state_t : arbiter FSM states
//   I2C_WR/RD   : encoding of the operation bit seen by the master engine
//   SYS_FREQ/I2C_FREQ : nominal system and bus clock rates of the platform
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } arb_state_t;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  localparam int SYS_FREQ = 40_000_000;
  localparam int I2C_FREQ = 100_000;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// -----------------------------------------------------------------------------
// i2c_txn_arbiter_if
// Bundles the requester-side handshake and the master-engine handshake.
//   req/req_addr/req_rw/req_wdata : per-port request, packed per port
//   gnt/rsp_*                     : one-hot grant and completion response
//   m_newd/m_addr/m_op/m_din      : launch command toward the I2C engine
//   m_done/m_ack_err/m_dout       : completion status from the I2C engine
// Modports:
//   master : the arbiter (drives grants, responses and engine commands)
//   slave  : the surroundings (requesters plus the engine)
// -----------------------------------------------------------------------------
interface i2c_txn_arbiter_if #(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]   req;
  logic [NREQ*7-1:0] req_addr;
  logic [NREQ-1:0]   req_rw;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              m_newd;
  logic [6:0]        m_addr;
  logic              m_op;
  logic [7:0]        m_din;
  logic              m_done;
  logic              m_ack_err;
  logic [7:0]        m_dout;

  modport master (
    input  req, req_addr, req_rw, req_wdata, m_done, m_ack_err, m_dout,
    output gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output m_newd, m_addr, m_op, m_din
  );

  modport slave (
    output req, req_addr, req_rw, req_wdata, m_done, m_ack_err, m_dout,
    input  gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  m_newd, m_addr, m_op, m_din
  );

endinterface

// File: rtl/i2c_txn_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin winner selection. The search starts one past the stored pointer
// and wraps modulo NREQ; the first set request wins. The pointer only moves
// on advance_i, taking the index of the port that was just served.
//   clk, rst    : clock, synchronous active-high reset (pointer -> NREQ-1)
//   req_i       : request vector
//   advance_i   : load adv_idx_i into the pointer
//   adv_idx_i   : index of the port just served
//   any_o       : at least one request is set
//   win_oh_o    : one-hot winner (combinational)
//   win_idx_o   : binary winner index (combinational)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    advance_i,
  input  logic [$clog2(NREQ)-1:0] adv_idx_i,
  output logic                    any_o,
  output logic [NREQ-1:0]         win_oh_o,
  output logic [$clog2(NREQ)-1:0] win_idx_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;

  // NOTE: every variable written here gets a value before any condition,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    any_o     = 1'b0;
    win_oh_o  = '0;
    win_idx_o = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o           = 1'b1;
        win_oh_o[cand]  = 1'b1;
        win_idx_o       = cand;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (advance_i) begin
      ptr_q <= adv_idx_i;
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_txn_arbiter
// Shares one byte-oriented I2C master engine among NREQ requesters. A winner
// is chosen round-robin, its request is latched and launched on the engine,
// and the engine's completion (or a timeout) is returned to that port as a
// single-cycle rsp_valid pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : i2c_txn_arbiter_if.master (requester and engine handshakes)
// Parameters:
//   NREQ        : number of requester ports (2..8)
//   TIMEOUT_CYC : cycles allowed from launch to m_done before aborting
// -----------------------------------------------------------------------------
module i2c_txn_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 16384
) (
  input logic               clk,
  input logic               rst,
  i2c_txn_arbiter_if.master bus
);

  import i2c_pkg::*;

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t      state_q,   state_d;
  logic [NREQ-1:0] gnt_q,     gnt_d;
  logic [IW-1:0]   win_q,     win_d;
  logic [6:0]      m_addr_q,  m_addr_d;
  logic            m_op_q,    m_op_d;
  logic [7:0]      m_din_q,   m_din_d;
  logic            m_newd_q,  m_newd_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic            ack_err_q, ack_err_d;
  logic [7:0]      dout_q,    dout_d;
  logic            tmo_q,     tmo_d;

  logic            arb_any;
  logic [NREQ-1:0] arb_oh;
  logic [IW-1:0]   arb_idx;
  logic [6:0]      sel_addr;
  logic            sel_rw;
  logic [7:0]      sel_wdata;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.req),
    .advance_i (state_q == RESP),
    .adv_idx_i (win_q),
    .any_o     (arb_any),
    .win_oh_o  (arb_oh),
    .win_idx_o (arb_idx)
  );

  // Mux the winning port's request fields out of the packed vectors.
  always_comb begin
    sel_addr  = '0;
    sel_rw    = 1'b0;
    sel_wdata = '0;
    for (int p = 0; p < NREQ; p++) begin
      if (arb_idx == IW'(p)) begin
        sel_addr  = bus.req_addr[p*7 +: 7];
        sel_rw    = bus.req_rw[p];
        sel_wdata = bus.req_wdata[p*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    win_d     = win_q;
    m_addr_d  = m_addr_q;
    m_op_d    = m_op_q;
    m_din_d   = m_din_q;
    m_newd_d  = 1'b0;
    cnt_d     = cnt_q;
    ack_err_d = ack_err_q;
    dout_d    = dout_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d    = arb_oh;
          win_d    = arb_idx;
          m_addr_d = sel_addr;
          m_op_d   = sel_rw;
          m_din_d  = sel_wdata;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        // The launch pulse is registered, so it shows up in the first WAIT
        // cycle, one cycle after gnt, while the counter reads 0.
        m_newd_d  = 1'b1;
        cnt_d     = '0;
        ack_err_d = 1'b0;
        dout_d    = '0;
        tmo_d     = 1'b0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnt_q != CW'(TIMEOUT_CYC)) cnt_d = cnt_q + CW'(1);
        // A completion in the last allowed cycle beats the timeout.
        if (bus.m_done) begin
          ack_err_d = bus.m_ack_err;
          dout_d    = bus.m_dout;
          state_d   = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      win_q     <= '0;
      m_addr_q  <= '0;
      m_op_q    <= 1'b0;
      m_din_q   <= '0;
      m_newd_q  <= 1'b0;
      cnt_q     <= '0;
      ack_err_q <= 1'b0;
      dout_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      win_q     <= win_d;
      m_addr_q  <= m_addr_d;
      m_op_q    <= m_op_d;
      m_din_q   <= m_din_d;
      m_newd_q  <= m_newd_d;
      cnt_q     <= cnt_d;
      ack_err_q <= ack_err_d;
      dout_q    <= dout_d;
      tmo_q     <= tmo_d;
    end
  end

  logic in_resp;
  assign in_resp = (state_q == RESP);

  assign bus.gnt         = gnt_q;
  assign bus.m_newd      = m_newd_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_op        = m_op_q;
  assign bus.m_din       = m_din_q;
  assign bus.rsp_valid   = in_resp ? gnt_q : '0;
  assign bus.rsp_err     = in_resp & (ack_err_q | tmo_q);
  assign bus.rsp_timeout = in_resp & tmo_q;
  assign bus.rsp_rdata   = (in_resp && m_op_q == I2C_RD && !ack_err_q && !tmo_q)
                           ? dout_q : '0;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_txn_arbiter
// Self-checking bench for i2c_txn_arbiter. The bench plays both the
// requesters and the I2C engine. A transaction-level model (pending set,
// last-served port, response latency formula) predicts each grant and
// response. Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_i2c_txn_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Requester model: what each port currently presents.
  bit         pend   [NREQ];
  logic [6:0] addr_a [NREQ];
  bit         rw_a   [NREQ];
  logic [7:0] wd_a   [NREQ];
  int         last;  // port served most recently (reset: NREQ-1)

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] one;
    one = 1;
    return (w < 0) ? '0 : (one << w);
  endfunction

  // Round-robin rule: scan ports last+1, last+2, ... and take the first pending one.
  function automatic int model_pick();
    for (int i = 1; i <= NREQ; i++) begin
      if (pend[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int p = 0; p < NREQ; p++) begin
      bus.req[p]             = pend[p];
      bus.req_addr[p*7 +: 7] = addr_a[p];
      bus.req_rw[p]          = rw_a[p];
      bus.req_wdata[p*8 +: 8] = wd_a[p];
    end
  endtask

  task automatic new_req(input int p);
    pend[p]   = 1'b1;
    addr_a[p] = 7'($urandom);
    rw_a[p]   = 1'($urandom);
    wd_a[p]   = 8'($urandom);
  endtask

  task automatic set_req(input int p, input logic [6:0] a, input bit rw, input logic [7:0] wd);
    pend[p]   = 1'b1;
    addr_a[p] = a;
    rw_a[p]   = rw;
    wd_a[p]   = wd;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.m_done = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_gnt",     32'(bus.gnt), 0);
    check("rst_rsp",     32'(bus.rsp_valid), 0);
    check("rst_newd",    32'(bus.m_newd), 0);
    check("rst_maddr",   32'(bus.m_addr), 0);
    check("rst_mop",     32'(bus.m_op), 0);
    check("rst_mdin",    32'(bus.m_din), 0);
    check("rst_err",     32'(bus.rsp_err), 0);
    check("rst_tmo",     32'(bus.rsp_timeout), 0);
    check("rst_rdata",   32'(bus.rsp_rdata), 0);
    rst  = 1'b0;
    last = NREQ - 1;
  endtask

  // One full transaction, entered and left at a negedge in IDLE.
  //   d     : cycles after the m_newd cycle before the engine pulses m_done
  //           (d >= TMO means the engine never answers in time)
  //   drop  : winner lowers req while granted
  //   hold  : winner requests again right after its response
  //   more  : other idle ports may raise new requests at response time
  task automatic one_txn(input int d, input bit ack, input logic [7:0] dout,
                         input bit drop, input bit hold, input bit more,
                         output logic [NREQ-1:0] g_obs);
    int         w;
    int         cyc;
    bit         to;
    logic [6:0] e_addr;
    bit         e_rw;
    logic [7:0] e_wd;

    drive_reqs();
    bus.m_done    = 1'($urandom);  // outside WAIT: must be ignored
    bus.m_ack_err = 1'($urandom);
    bus.m_dout    = 8'($urandom);
    w = model_pick();
    @(posedge clk); @(negedge clk);
    g_obs = bus.gnt;
    check("gnt", 32'(bus.gnt), 32'(onehot(w)));
    check("newd_early", 32'(bus.m_newd), 0);
    e_addr = addr_a[w];
    e_rw   = rw_a[w];
    e_wd   = wd_a[w];

    // Request already latched: scramble the winner's inputs.
    addr_a[w] = 7'($urandom);
    rw_a[w]   = 1'($urandom);
    wd_a[w]   = 8'($urandom);
    if (drop) pend[w] = 1'b0;
    drive_reqs();
    bus.m_done = 1'($urandom);
    @(posedge clk); @(negedge clk);
    check("newd", 32'(bus.m_newd), 1);
    check("maddr", 32'(bus.m_addr), 32'(e_addr));
    check("mop", 32'(bus.m_op), 32'(e_rw));
    check("mdin", 32'(bus.m_din), 32'(e_wd));

    cyc = -1;
    for (int k = 0; k < TMO + 4; k++) begin
      if (bus.rsp_valid != '0) begin
        cyc = k;
        break;
      end
      bus.m_done    = (k == d);
      bus.m_ack_err = (k == d) ? ack : 1'($urandom);
      bus.m_dout    = (k == d) ? dout : 8'($urandom);
      @(posedge clk); @(negedge clk);
    end
    bus.m_done = 1'b0;

    to = (d > TMO - 1);
    check("rsp_latency", 32'(cyc), to ? 32'(TMO) : 32'(d + 1));
    if (cyc < 0) begin
      do_reset();
      for (int p = 0; p < NREQ; p++) pend[p] = 1'b0;
      drive_reqs();
      return;
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'(onehot(w)));
    check("rsp_err", 32'(bus.rsp_err), 32'(to || ack));
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'(to));
    check("rsp_rdata", 32'(bus.rsp_rdata), (e_rw && !ack && !to) ? 32'(dout) : 0);
    check("gnt_in_resp", 32'(bus.gnt), 32'(onehot(w)));
    check("maddr_stable", 32'(bus.m_addr), 32'(e_addr));

    last    = w;
    pend[w] = hold;
    if (more) begin
      for (int p = 0; p < NREQ; p++) begin
        if (p != w && !pend[p] && $urandom_range(0, 2) == 0) new_req(p);
      end
    end
    drive_reqs();
    @(posedge clk); @(negedge clk);
    check("idle_gnt", 32'(bus.gnt), 0);
    check("idle_rsp", 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] acc;
    int              exp_ord [5];
    int              d;

    exp_ord = '{0, 1, 2, 3, 0};
    for (int p = 0; p < NREQ; p++) begin
      pend[p] = 1'b0; addr_a[p] = '0; rw_a[p] = 1'b0; wd_a[p] = '0;
    end
    drive_reqs();
    bus.m_done = 1'b0; bus.m_ack_err = 1'b0; bus.m_dout = '0;
    last = NREQ - 1;
    repeat (3) @(negedge clk);
    do_reset();

    // Single write on port 0
    set_req(0, 7'h12, 1'b0, 8'hA5);
    one_txn(3, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, g);
    check("t1_port", 32'(g), 32'h1);

    // Read on port 2
    set_req(2, 7'h35, 1'b1, 8'h00);
    one_txn(1, 1'b0, 8'h35, 1'b0, 1'b0, 1'b0, g);
    check("t2_port", 32'(g), 32'h4);

    // NACK on port 1 (read so that rdata must be forced to 0)
    set_req(1, 7'h50, 1'b1, 8'h11);
    one_txn(2, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, g);

    // Timeout, then completion exactly in the last allowed cycle
    set_req(3, 7'h7F, 1'b0, 8'h3C);
    one_txn(1000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, g);
    set_req(3, 7'h22, 1'b1, 8'h00);
    one_txn(TMO - 1, 1'b0, 8'h9E, 1'b0, 1'b0, 1'b0, g);

    // Round-robin with everyone requesting and an instant engine
    do_reset();
    for (int p = 0; p < NREQ; p++) new_req(p);
    for (int i = 0; i < 5; i++) begin
      one_txn(0, 1'b0, 8'($urandom), 1'b0, 1'b1, 1'b0, g);
      check("rr_order", 32'(g), 32'(onehot(exp_ord[i])));
    end

    // Reset in the middle of WAIT (pointer is 0 here, so port 1 wins)
    for (int p = 0; p < NREQ; p++) pend[p] = 1'b0;
    set_req(1, 7'h44, 1'b0, 8'h77);
    drive_reqs();
    @(posedge clk); @(negedge clk);
    check("t6_gnt", 32'(bus.gnt), 32'h2);
    @(posedge clk); @(negedge clk);
    check("t6_newd", 32'(bus.m_newd), 1);
    repeat (3) @(negedge clk);
    pend[1] = 1'b0;
    drive_reqs();
    do_reset();
    bus.m_done = 1'b1; bus.m_ack_err = 1'b0; bus.m_dout = 8'hEE;
    acc = '0;
    @(posedge clk); @(negedge clk);
    bus.m_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = acc | bus.rsp_valid | bus.gnt;
      @(posedge clk); @(negedge clk);
    end
    check("t6_no_late_rsp", 32'(acc), 0);
    new_req(0);
    new_req(3);
    one_txn(2, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, g);
    check("t6_ptr_reset", 32'(g), 32'h1);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int r;
      bit any;
      any = 1'b0;
      for (int p = 0; p < NREQ; p++) any |= pend[p];
      if (!any) new_req($urandom_range(0, NREQ - 1));
      r = $urandom_range(0, 15);
      if (r < 10)       d = $urandom_range(0, 3);
      else if (r < 13)  d = $urandom_range(4, 20);
      else if (r == 13) d = TMO - 1;
      else if (r == 14) d = TMO - 2;
      else              d = TMO + 50;
      one_txn(d, ($urandom_range(0, 3) == 0), 8'($urandom),
              ($urandom_range(0, 7) == 0), 1'($urandom), 1'b1, g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one byte-oriented I2C master engine among NREQ requester ports.
- Each request is a single-byte transaction to a 7-bit device: write or read.
- Grants are round-robin. The block launches the engine, waits for completion or timeout, and routes the response back to the winning requester.
- Sits between the software/sequencer side and the I2C master that drives scl/sda toward the 128-byte slave memory devices.

Parameters:
- NREQ, 4, number of requester ports (2..8).
- TIMEOUT_CYC, 16384, clk cycles allowed from launch to m_done before the transaction is aborted with a timeout.

Ports:
- clk  in  1  system clock (40 MHz nominal).
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- req  in  NREQ  per-port request level; held until that port's rsp_valid.
- req_addr  in  NREQ*7  per-port 7-bit device address; port i uses bits [7i+6:7i].
- req_rw  in  NREQ  per-port operation: 1 = read, 0 = write.
- req_wdata  in  NREQ*8  per-port write byte; port i uses bits [8i+7:8i].
- gnt  out  NREQ  one-hot grant; high from grant until response.
- rsp_valid  out  NREQ  one-hot, single-cycle completion pulse.
- rsp_rdata  out  8  read byte, valid with rsp_valid; 0 for writes.
- rsp_err  out  1  valid with rsp_valid; set on NACK or timeout.
- rsp_timeout  out  1  valid with rsp_valid; set on timeout only.
- m_newd  out  1  single-cycle launch pulse to the master engine.
- m_addr  out  7  device address to the engine.
- m_op  out  1  operation to the engine: 1 = read.
- m_din  out  8  write byte to the engine.
- m_done  in  1  single-cycle completion pulse from the engine.
- m_ack_err  in  1  NACK flag, valid with m_done.
- m_dout  in  8  read byte, valid with m_done.

Behaviour:
- Reset: every output 0; state IDLE; rr pointer = NREQ-1, so port 0 has highest priority first; timeout counter 0. Reset mid-transaction aborts it with no response pulse; the engine is left to finish on its own.
- States and transitions:
  - IDLE: if any req bit is set, pick a winner (round-robin), latch its addr/rw/wdata into m_* registers, set gnt[winner], go to LAUNCH. Otherwise stay.
  - LAUNCH: m_newd=1 for exactly this cycle; clear the counter; go to WAIT.
  - WAIT: counter increments each cycle.
    - m_done=1: capture m_ack_err and m_dout; go to RESP.
    - Else, counter == TIMEOUT_CYC-1: flag timeout; go to RESP.
    - m_done and timeout in the same cycle: m_done wins.
  - RESP: rsp_valid[winner]=1 for one cycle; gnt is cleared at the end of the cycle; rr pointer = winner; go to IDLE.
    - rsp_rdata = captured m_dout if read and no error, else 0.
    - rsp_err = ack_err OR timeout; rsp_timeout = timeout.
- Latency:
  - req seen in IDLE at edge t → gnt high at t+1.
  - m_newd at t+2.
  - rsp_valid the cycle after m_done.
  - Next grant no earlier than 1 cycle after RESP; the IDLE re-arbitration cycle is mandatory.
- Round-robin: search order starts at pointer+1 modulo NREQ; the first set req wins. A port cannot win twice in a row while another port is requesting.
- m_addr/m_op/m_din stay stable from LAUNCH through RESP. Requester inputs are ignored after latching.
- req dropped while granted: the transaction still completes and rsp_valid still pulses. Requesters must ignore an unsolicited pulse.
- m_done outside WAIT is ignored.
- Timeout counter width: $clog2(TIMEOUT_CYC+1), saturating. No overflow is possible.

Decomposition:
- Package i2c_pkg:
  - state enum arb_state_t {IDLE, LAUNCH, WAIT, RESP};
  - I2C_WR=1'b0, I2C_RD=1'b1;
  - SYS_FREQ=40_000_000, I2C_FREQ=100_000.
- Sub-module rr_arbiter: NREQ-wide, combinational one-hot winner from req and pointer, plus a registered pointer update on an "advance" strobe. Unit-testable alone.

Test Plan:
1. Single write: req=4'b0001, addr=7'h12, rw=0, wdata=8'hA5 → gnt=0001 next cycle; m_newd one cycle later with m_addr=12, m_op=0, m_din=A5. Engine returns m_done with ack_err=0 → rsp_valid=0001, rsp_err=0, rsp_rdata=00.
2. Read: port 2, addr=7'h35, rw=1; engine returns m_dout=8'h35, ack_err=0 → rsp_valid=0100, rsp_rdata=35, rsp_err=0.
3. Round-robin: req=1111 held continuously with instant engine completion → grant order 0,1,2,3,0. No port is granted twice consecutively.
4. NACK: port 1 write; engine m_done with ack_err=1 → rsp_valid=0010, rsp_err=1, rsp_timeout=0.
5. Timeout: TIMEOUT_CYC=100, engine never pulses m_done → rsp_valid exactly 100 cycles after m_newd with rsp_err=1, rsp_timeout=1. Then m_done=1 in the same cycle as count 99 → normal response with rsp_timeout=0.
6. Reset mid-WAIT: rst for 1 cycle → gnt, rsp_valid, m_newd all 0; state IDLE; pointer back to NREQ-1. A late m_done produces no response.
